// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an input FIFO and valid/ready handshake.
// Optional `UART_TX_FIFO_CTS_EN adds a synchronised active-low clear-to-send input.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
`ifdef UART_TX_FIFO_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          in_ready,
  output logic                          tx_pin,
  output logic                          busy,
  output logic                          idle,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CYCLE = CLK_FREQ / BAUD_RATE;
  localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY == 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (CYCLE < 1) begin : g_bad_cycle
      $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         baud_cnt;
  logic                  baud_tick;
  logic [3:0]            bit_cnt;
  logic [DATA_BITS-1:0]  sreg, sreg_nxt;
  logic                  par_q, par_nxt;
  logic                  tx_d;
  logic                  cts_ok;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  full, empty, push, pop;
  logic [DATA_BITS-1:0]  pop_data;

  // ---------------- FIFO ----------------
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  // An empty FIFO can only be popped by the STOP chain on a same-cycle push: bypass the word.
  assign pop_data = empty ? in_data : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- flow control ----------------
`ifdef UART_TX_FIFO_CTS_EN
  logic [1:0] cts_sync;
  always_ff @(posedge clk) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end
  assign cts_ok = !cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  // ---------------- bit timing ----------------
  assign baud_tick = (baud_cnt == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) baud_cnt <= '0;
    else if (baud_tick)         baud_cnt <= '0;
    else                        baud_cnt <= baud_cnt + CW'(1);
  end

  // Counts data bits in DATA and stop bits in STOP; cleared on every state change.
  always_ff @(posedge clk) begin
    if (rst || state != state_nxt) bit_cnt <= '0;
    else if (baud_tick)            bit_cnt <= bit_cnt + 4'd1;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!empty && cts_ok) state_nxt = S_START;
      S_START:  if (baud_tick) state_nxt = S_DATA;
      S_DATA:   if (baud_tick && bit_cnt == DATA_LAST)
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (baud_tick) state_nxt = S_STOP;
      S_STOP:   if (baud_tick && bit_cnt == STOP_LAST)
                  state_nxt = ((!empty || push) && cts_ok) ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode looks at the next state so tx_pin can be registered without a bit of lag.
  always_comb begin
    pop      = (state_nxt == S_START) && (state != S_START);
    sreg_nxt = sreg;
    par_nxt  = par_q;
    if (pop) begin
      sreg_nxt = pop_data;
      par_nxt  = (^pop_data) ^ PAR_ODD;
    end else if (state == S_DATA && baud_tick) begin
      sreg_nxt = sreg >> 1;
    end
    case (state_nxt)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sreg_nxt[0];
      S_PARITY: tx_d = par_nxt;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg   <= '0;
      par_q  <= 1'b0;
      tx_pin <= 1'b1;
    end else begin
      sreg   <= sreg_nxt;
      par_q  <= par_nxt;
      tx_pin <= tx_d;
    end
  end

  assign busy  = (state != S_IDLE);
  assign idle  = (state == S_IDLE) && empty;
  assign level = count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1 instance and a 7-bit odd-parity 2-stop instance,
// both at 8 clocks per bit. Define UART_TX_FIFO_CTS_EN to also exercise clear-to-send.
module tb_uart_tx_fifo;

  localparam int CLKF = 80;
  localparam int BAUD = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid0, in_ready0, tx0, busy0, idle0;
  logic [7:0] in_data0;
  logic [2:0] level0;
  logic       in_valid1, in_ready1, tx1, busy1, idle1;
  logic [6:0] in_data1;
  logic [1:0] level1;
`ifdef UART_TX_FIFO_CTS_EN
  logic       cts_n = 1'b0;
`endif

  uart_tx_fifo #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
`ifdef UART_TX_FIFO_CTS_EN
    .cts_n(cts_n),
`endif
    .in_ready(in_ready0), .tx_pin(tx0), .busy(busy0), .idle(idle0), .level(level0));

  uart_tx_fifo #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
`ifdef UART_TX_FIFO_CTS_EN
    .cts_n(cts_n),
`endif
    .in_ready(in_ready1), .tx_pin(tx1), .busy(busy1), .idle(idle1), .level(level1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic txs(input int sel);
    return (sel != 0) ? tx1 : tx0;
  endfunction

  function automatic logic busys(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction

  // Entered at the middle of the start bit; returns at the middle of the last stop bit.
  task automatic run_frame(input int sel, input string name, input logic [11:0] fr, input int n);
    chk($sformatf("%s bit0", name), txs(sel), fr[0]);
    for (int i = 1; i < n; i++) begin
      repeat (8) step();
      chk($sformatf("%s bit%0d", name, i), txs(sel), fr[i]);
    end
  endtask

  task automatic frame_gap_end(input int sel, input string name);
    repeat (4) step();
    chk($sformatf("%s end tx", name), txs(sel), 1'b1);
    chk($sformatf("%s end busy", name), busys(sel), 1'b0);
    chk($sformatf("%s end idle", name), (sel != 0) ? idle1 : idle0, 1'b1);
  endtask

  task automatic frame_chain(input int sel, input string name);
    repeat (4) step();
    chk($sformatf("%s chain start", name), txs(sel), 1'b0);
    chk($sformatf("%s chain busy", name), busys(sel), 1'b1);
    repeat (4) step();
  endtask

  initial begin
    logic       quiet;
    logic [2:0] lvl_exp [6];
    lvl_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    in_valid0 = 1'b0; in_data0 = '0;
    in_valid1 = 1'b0; in_data1 = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst tx0", tx0, 1'b1);
    chk("rst busy0", busy0, 1'b0);
    chk("rst idle0", idle0, 1'b1);
    chk("rst level0", level0, 3'd0);
    chk("rst in_ready0", in_ready0, 1'b0);
    chk("rst tx1", tx1, 1'b1);
    rst = 1'b0;
    repeat (3) step();
    chk("post rst in_ready0", in_ready0, 1'b1);

    // Single 0x41 frame on the 8N1 instance
    in_valid0 = 1'b1; in_data0 = 8'h41;
    step();
    in_valid0 = 1'b0;
    chk("w41 level", level0, 3'd1);
    chk("w41 tx before start", tx0, 1'b1);
    chk("w41 idle", idle0, 1'b0);
    step();
    chk("w41 start latency", tx0, 1'b0);
    chk("w41 popped level", level0, 3'd0);
    repeat (4) step();
    run_frame(0, "f41", 12'b00_1_01000001_0, 10);
    frame_gap_end(0, "f41");

    // Push on the last stop clock chains immediately
    in_valid0 = 1'b1; in_data0 = 8'h41;
    step();
    in_valid0 = 1'b0;
    step();
    repeat (4) step();
    run_frame(0, "c41", 12'b00_1_01000001_0, 10);
    repeat (3) step();
    in_valid0 = 1'b1; in_data0 = 8'hA5;
    step();
    in_valid0 = 1'b0;
    chk("chain push tx", tx0, 1'b0);
    chk("chain push level", level0, 3'd0);
    chk("chain push busy", busy0, 1'b1);
    repeat (4) step();
    run_frame(0, "cA5", 12'b00_1_10100101_0, 10);
    frame_gap_end(0, "cA5");

    // FIFO fill: 6 offered, 5 accepted, back-to-back frames
    for (int i = 0; i < 6; i++) begin
      in_valid0 = 1'b1; in_data0 = 8'(i + 1);
      chk($sformatf("fill ready%0d", i), in_ready0, (i < 5) ? 1'b1 : 1'b0);
      step();
      chk($sformatf("fill level%0d", i), level0, lvl_exp[i]);
    end
    in_valid0 = 1'b0;
    run_frame(0, "q01", 12'b00_1_00000001_0, 10);
    frame_chain(0, "q01");
    run_frame(0, "q02", 12'b00_1_00000010_0, 10);
    frame_chain(0, "q02");
    run_frame(0, "q03", 12'b00_1_00000011_0, 10);
    frame_chain(0, "q03");
    run_frame(0, "q04", 12'b00_1_00000100_0, 10);
    frame_chain(0, "q04");
    run_frame(0, "q05", 12'b00_1_00000101_0, 10);
    frame_gap_end(0, "q05");

    // 7-bit odd parity, 2 stop bits: 0x55 -> parity 1, 0x43 -> parity 0
    in_valid1 = 1'b1; in_data1 = 7'h55;
    step();
    in_data1 = 7'h43;
    step();
    in_valid1 = 1'b0;
    chk("u1 start", tx1, 1'b0);
    chk("u1 level", level1, 2'd1);
    repeat (4) step();
    run_frame(1, "p55", 12'b0_11_1_1010101_0, 11);
    frame_chain(1, "p55");
    run_frame(1, "p43", 12'b0_11_0_1000011_0, 11);
    frame_gap_end(1, "p43");

    // Reset during data bit 3 with words queued
    in_valid0 = 1'b1; in_data0 = 8'h11;
    step();
    in_data0 = 8'h22;
    step();
    in_data0 = 8'h33;
    step();
    in_valid0 = 1'b0;
    chk("pre rst level", level0, 3'd2);
    repeat (34) step();
    chk("pre rst data bit3", tx0, 1'b0);
    chk("pre rst busy", busy0, 1'b1);
    rst = 1'b1;
    step();
    chk("mid rst tx", tx0, 1'b1);
    chk("mid rst level", level0, 3'd0);
    chk("mid rst busy", busy0, 1'b0);
    chk("mid rst idle", idle0, 1'b1);
    chk("mid rst in_ready", in_ready0, 1'b0);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || level0 !== 3'd0) quiet = 1'b0;
    end
    chk("post rst quiet", quiet, 1'b1);
    chk("post rst ready", in_ready0, 1'b1);

`ifdef UART_TX_FIFO_CTS_EN
    begin
      logic found;
      cts_n = 1'b1;
      repeat (3) step();
      in_valid0 = 1'b1; in_data0 = 8'h41;
      step();
      in_valid0 = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
        step();
        if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
      end
      chk("cts hold tx", quiet, 1'b1);
      chk("cts hold level", level0, 3'd1);
      cts_n = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
        step();
        if (tx0 === 1'b0) found = 1'b1;
      end
      chk("cts release start", found, 1'b1);
      repeat (4) step();
      cts_n = 1'b1;
      run_frame(0, "cts41", 12'b00_1_01000001_0, 10);
      frame_gap_end(0, "cts41");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
